fetch_queue: RTL and testbench
==============================

Name: fetch_queue

Overview:
- Instruction buffer directly downstream of the fetch stage, upstream of decode.
- Captures {pc, instruction word} pairs returned for each fetch address and presents them in order to decode over a valid/ready handshake.
- Decouples fetch from decode stalls.
- Discards every buffered entry when the control unit redirects the PC on a jump or branch.

Parameters:
- DEPTH, 2, number of entries. Power of two, minimum 2.
- NOP, 32'h00000013, instruction word driven on out_instr while the queue is empty (addi x0,x0,0).

Ports:
- clk  in  1  clock; all state updates on posedge
- rst  in  1  synchronous reset, active-high
- flush  in  1  redirect from control unit (jmp); empties the queue
- in_valid  in  1  fetch offers an entry this cycle
- in_ready  out  1  queue can accept an entry this cycle
- in_pc  in  32  address the instruction was fetched from
- in_instr  in  32  instruction word from instruction memory
- out_valid  out  1  head entry available to decode
- out_ready  in  1  decode consumes head entry this cycle
- out_pc  out  32  pc of head entry
- out_instr  out  32  instruction of head entry; NOP when empty
- count  out  $clog2(DEPTH)+1  current number of stored entries

Behaviour:
- Storage:
  - DEPTH-entry circular buffer of 64-bit {pc, instr}.
  - Write pointer, read pointer and count registers; pointers are $clog2(DEPTH) bits and wrap modulo DEPTH.
- Handshake:
  - push = in_valid & in_ready.
  - pop = out_valid & out_ready.
- Output and ready derivation:
  - in_ready = (count != DEPTH). Depends on registered state only, never on out_ready (no combinational in→out path).
  - out_valid = (count != 0).
  - out_pc/out_instr = entry at the read pointer when out_valid, else out_pc = 0 and out_instr = NOP.
- Latency:
  - Entry pushed in cycle N is visible on out_* in cycle N+1.
  - No same-cycle bypass: an empty queue stays out_valid = 0 in the push cycle.
- Count update (when flush = 0): count_next = count + push − pop.
  - Push and pop in the same cycle are legal whenever count is 1..DEPTH−1: count unchanged, both pointers advance.
- Full: in_ready = 0, so a push is impossible. A pop in the same cycle does not enable a push in that cycle; in_ready rises the following cycle.
- Empty: pop is impossible because out_valid = 0. out_ready is ignored.
- Flush (priority over push and pop):
  - Next cycle count = 0, write and read pointers = 0.
  - Any same-cycle push is discarded and any same-cycle pop is void.
  - Stored data need not be cleared.
  - Flush held for several cycles keeps the queue empty; in_ready stays 1 throughout (count = 0).
- Reset (rst = 1, synchronous; priority over flush):
  - Next cycle count = 0, pointers = 0.
  - Outputs after reset: in_ready = 1, out_valid = 0, out_pc = 0, out_instr = NOP, count = 0.
  - Reset asserted mid-stream discards all entries identically to flush.
- Ordering: entries leave strictly in push order across pointer wrap-around.

Test Plan:
- Reset then idle → in_ready = 1, out_valid = 0, out_instr = 32'h00000013, count = 0.
- Push (0x0,0xAAAA0001) then (0x4,0xAAAA0002) with out_ready = 0 → count = 2, in_ready = 0. Third offer (0x8,…) is not accepted. Raise out_ready → outputs 0x0 then 0x4 in order, count returns to 0.
- Continuous in_valid = out_ready = 1 over 10 entries pc 0x0..0x24 → after a 1-cycle fill latency, one entry per cycle. Pointers wrap, no loss or reorder, count stays 1.
- count = 2 with flush = 1 and in_valid = 1 (pc 0x8) in the same cycle → next cycle count = 0, out_valid = 0. pc 0x8 never appears at the output. Push of 0x100 the following cycle appears next cycle as the head.
- Full queue with out_ready = 1 and in_valid = 1 in the same cycle → one pop, no push, count = 1. in_ready = 1 in the next cycle.
- rst asserted with count = 1 and flush = 1 simultaneously → next cycle all outputs at reset values. A pending entry pushed in the reset cycle is discarded.

Source files
------------

// File: rtl/fetch_queue.sv
// In-order instruction buffer between fetch and decode. Holds {pc, instr} pairs,
// presents the oldest to decode and drops everything on a PC redirect (flush).
module fetch_queue #(
  parameter int unsigned DEPTH = 2,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [31:0]              in_pc,
  input  logic [31:0]              in_instr,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [31:0]              out_pc,
  output logic [31:0]              out_instr,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = PtrW + 1;

  logic [63:0]     mem_q [DEPTH];
  logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CntW-1:0] count_q, count_d;
  logic            push, pop, write_en;
  logic [63:0]     head;

  // Ready and valid come from registered count only, so no in->out comb path.
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = (count_q != '0);
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign write_en  = push & ~flush & ~rst;

  assign head      = mem_q[rd_ptr_q];
  assign out_pc    = out_valid ? head[63:32] : 32'h0;
  assign out_instr = out_valid ? head[31:0]  : NOP;
  assign count     = count_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      // Pointers wrap naturally since DEPTH is a power of two.
      if (push) wr_ptr_d = wr_ptr_q + PtrW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PtrW'(1);
      count_d = count_q + CntW'(push) - CntW'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    if (write_en) mem_q[wr_ptr_q] <= {in_pc, in_instr};
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue model tracks expected contents and every
// cycle the DUT's count, handshake flags and head entry are compared against it.
module tb_fetch_queue;

  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] NOP   = 32'h00000013;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] in_pc, in_instr, out_pc, out_instr;
  logic [$clog2(DEPTH):0] count;

  int          n_tests = 0;
  int          n_fail  = 0;
  bit          mon_en  = 1'b0;
  logic [63:0] sb [$];

  fetch_queue #(.DEPTH(DEPTH), .NOP(NOP)) dut (
    .clk       (clk),
    .rst       (rst),
    .flush     (flush),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_pc     (in_pc),
    .in_instr  (in_instr),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_pc    (out_pc),
    .out_instr (out_instr),
    .count     (count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Inputs change #1 after posedge; the monitor samples on negedge.
  always @(negedge clk) begin
    int n;
    if (mon_en) begin
      n = sb.size();
      check("count", 64'(count), 64'(n));
      check("in_ready", 64'(in_ready), 64'(n != DEPTH));
      check("out_valid", 64'(out_valid), 64'(n != 0));
      if (n == 0) begin
        check("out_pc_empty", 64'(out_pc), 64'h0);
        check("out_instr_empty", 64'(out_instr), 64'(NOP));
      end else begin
        check("head", {out_pc, out_instr}, sb[0]);
      end
      if (rst || flush) begin
        sb.delete();
      end else begin
        if (out_ready && n != 0) void'(sb.pop_front());
        if (in_valid && n != DEPTH) sb.push_back({in_pc, in_instr});
      end
    end
  end

  task automatic step(input logic r, input logic f, input logic iv, input logic [31:0] pc,
                      input logic [31:0] instr, input logic ordy);
    rst       = r;
    flush     = f;
    in_valid  = iv;
    in_pc     = pc;
    in_instr  = instr;
    out_ready = ordy;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    in_pc = '0; in_instr = '0;
    repeat (2) @(posedge clk);
    #1;
    mon_en = 1'b1;

    // Idle after reset.
    repeat (2) step(0, 0, 0, 0, 0, 0);

    // Fill to full, third offer refused, then drain in order.
    step(0, 0, 1, 32'h0, 32'hAAAA0001, 0);
    step(0, 0, 1, 32'h4, 32'hAAAA0002, 0);
    step(0, 0, 1, 32'h8, 32'hAAAA0003, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);

    // Streaming through pointer wrap.
    for (int i = 0; i < 10; i++) step(0, 0, 1, 32'(i * 4), 32'hBBBB0000 + 32'(i), 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Flush with a same-cycle push, then push right after.
    step(0, 0, 1, 32'h0, 32'hCCCC0000, 0);
    step(0, 0, 1, 32'h4, 32'hCCCC0004, 0);
    step(0, 1, 1, 32'h8, 32'hCCCC0008, 1);
    step(0, 0, 1, 32'h100, 32'hCCCC0100, 0);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 1, 0, 0, 0, 0);
    step(0, 1, 1, 32'h200, 32'h1, 1);
    step(0, 0, 0, 0, 0, 0);

    // Full with pop and offer: one pop, no push.
    step(0, 0, 1, 32'h10, 32'hDDDD0010, 0);
    step(0, 0, 1, 32'h14, 32'hDDDD0014, 0);
    step(0, 0, 1, 32'h18, 32'hDDDD0018, 1);
    step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    // Reset and flush together with a pending push.
    step(0, 0, 1, 32'h20, 32'hEEEE0020, 0);
    step(1, 1, 1, 32'h24, 32'hEEEE0024, 0);
    step(0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0);

    // Random traffic with occasional flush and reset.
    for (int i = 0; i < 300; i++) begin
      step(($urandom_range(0, 63) == 0), ($urandom_range(0, 15) == 0),
           1'($urandom_range(0, 1)), 32'h1000 + 32'(i * 4), $urandom,
           1'($urandom_range(0, 1)));
    end
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 1);
    step(0, 0, 0, 0, 0, 0);

    mon_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
